// File: rtl/lector_resultado_bcd_if.sv
// Bus between the multiplier register bank and the BCD result reader.
// The bank side drives the product and its done flag. The reader side returns
// the converted digits and its status.
interface lector_resultado_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic signed [WIDTH-1:0]    resultado;
    logic                       done;
    logic        [4*DIGITS-1:0] bcd;
    logic                       negativo;
    logic                       bcd_valid;
    logic                       busy;

    // Register bank / display side
    modport master (
        output resultado, done,
        input  bcd, negativo, bcd_valid, busy
    );

    // Reader side
    modport slave (
        input  resultado, done,
        output bcd, negativo, bcd_valid, busy
    );
endinterface

// File: rtl/lector_resultado_bcd.sv
// BCD result reader.
// On a rising edge of done, the module captures the signed product and splits
// it into a sign and a magnitude. It then converts the magnitude to packed BCD
// with a sequential double-dabble, doing one bit per clock. The completed
// digits, the sign and bcd_valid hold their values until the next capture.
module lector_resultado_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    lector_resultado_bcd_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0] mag_reg, mag_next;
    logic [BW-1:0]   scratch_reg, scratch_next;
    logic            sign_reg, sign_next;
    logic            done_prev_reg;
    logic [BW-1:0]   bcd_reg, bcd_next;
    logic            negativo_reg, negativo_next;
    logic            valid_reg, valid_next;
    logic            busy_reg, busy_next;

    logic            trigger;
    logic [WIDTH-1:0] abs_in;
    logic [BW-1:0]   scratch_adj;

    // A level that stays high fires only once. done_prev starts at 0, so a
    // done that is already high when reset is released also counts as an edge.
    assign trigger = bus.done & ~done_prev_reg;

    // Two's-complement magnitude. The most negative value wraps to itself,
    // and as an unsigned number that is the correct magnitude.
    assign abs_in = bus.resultado[WIDTH-1] ? (~bus.resultado + WIDTH'(1))
                                           : bus.resultado;

    // Double-dabble correction: every digit of 5 or more gets 3 added before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                          ? scratch_reg[4*gi +: 4] + 4'd3
                                          : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: triggers that arrive outside IDLE are dropped, not queued
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_ITER) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values for each state
    always_comb begin
        cnt_next      = cnt_reg;
        mag_next      = mag_reg;
        scratch_next  = scratch_reg;
        sign_next     = sign_reg;
        bcd_next      = bcd_reg;
        negativo_next = negativo_reg;
        valid_next    = valid_reg;
        busy_next     = busy_reg;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    mag_next     = abs_in;
                    sign_next    = bus.resultado[WIDTH-1];
                    scratch_next = '0;
                    cnt_next     = '0;
                    busy_next    = 1'b1;
                    valid_next   = 1'b0;
                end
            end
            SHIFT: begin
                scratch_next = {scratch_adj[BW-2:0], mag_reg[WIDTH-1]};
                mag_next     = {mag_reg[WIDTH-2:0], 1'b0};
                cnt_next     = cnt_reg + CW'(1);
            end
            FIN: begin
                bcd_next      = scratch_reg;
                negativo_next = sign_reg;
                valid_next    = 1'b1;
                busy_next     = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath, edge-detect and output registers; reset aborts any conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            mag_reg       <= '0;
            scratch_reg   <= '0;
            sign_reg      <= 1'b0;
            done_prev_reg <= 1'b0;
            bcd_reg       <= '0;
            negativo_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            mag_reg       <= mag_next;
            scratch_reg   <= scratch_next;
            sign_reg      <= sign_next;
            done_prev_reg <= bus.done;
            bcd_reg       <= bcd_next;
            negativo_reg  <= negativo_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.bcd       = bcd_reg;
    assign bus.negativo  = negativo_reg;
    assign bus.bcd_valid = valid_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_lector_resultado_bcd.sv
// Directed testbench for lector_resultado_bcd. All expected values are
// worked out by hand from the decimal value of each product.
module tb_lector_resultado_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    lector_resultado_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

    lector_resultado_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One clock edge. Afterwards the outputs are sampled and the inputs are driven 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the capture edge until bcd_valid rises. The wait is bounded.
    task automatic wait_valid(input string tag, output int edges);
        edges = 0;
        while (bus.bcd_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd17);
    endtask

    // One complete conversion. done pulses high only on the capture edge.
    task automatic run_conv(input string tag, input logic [15:0] val,
                            input logic [19:0] exp_bcd, input logic exp_neg);
        int edges;
        bus.resultado = val;
        bus.done      = 1'b1;
        tick();
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.done      = 1'b0;
        bus.resultado = 16'h5A5A;   // changes after the capture must be ignored
        wait_valid(tag, edges);
        chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        chk({tag, "_neg"}, 32'(bus.negativo), 32'(exp_neg));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int edges;
        int rises;
        int busy_cnt;
        logic prev_valid;

        bus.resultado = '0;
        bus.done      = 1'b0;

        // 1. reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_bcd",   32'(bus.bcd), 32'd0);
        chk("rst_neg",   32'(bus.negativo), 32'd0);
        chk("rst_valid", 32'(bus.bcd_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        // 2. basic conversion with detailed latency check
        bus.resultado = 16'd15;
        bus.done      = 1'b1;
        tick();
        chk("t2_busy_on",  32'(bus.busy), 32'd1);
        chk("t2_valid_lo", 32'(bus.bcd_valid), 32'd0);
        bus.done = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("t2_still_busy", 32'(bus.busy), 32'd1);
        chk("t2_not_valid",  32'(bus.bcd_valid), 32'd0);
        tick();
        chk("t2_bcd",   32'(bus.bcd), 32'h00015);
        chk("t2_neg",   32'(bus.negativo), 32'd0);
        chk("t2_valid", 32'(bus.bcd_valid), 32'd1);
        chk("t2_busy",  32'(bus.busy), 32'd0);

        // 3. arithmetic corner values
        run_conv("min_neg", 16'h8000, 20'h32768, 1'b1);
        run_conv("sq127",   16'd16129, 20'h16129, 1'b0);
        run_conv("zero",    16'd0,     20'h00000, 1'b0);
        run_conv("minus1",  16'hFFFF,  20'h00001, 1'b1);
        run_conv("n9999",   16'd9999,  20'h09999, 1'b0);

        // 4. a new trigger during SHIFT is ignored (-16256 = 16'hC080)
        bus.resultado = 16'hC080;
        bus.done      = 1'b1;
        tick();                         // capture edge
        bus.done = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        bus.resultado = 16'd99;
        bus.done      = 1'b1;
        tick();                         // edge 5
        edges = 5;
        while (bus.bcd_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        chk("t4_latency", 32'(edges), 32'd17);
        chk("t4_bcd", 32'(bus.bcd), 32'h16256);
        chk("t4_neg", 32'(bus.negativo), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy) busy_cnt++;
        end
        chk("t4_no_second", 32'(busy_cnt), 32'd0);
        chk("t4_hold_bcd",  32'(bus.bcd), 32'h16256);

        // 5. done held high for 40 edges gives exactly one bcd_valid rise
        bus.done = 1'b0;
        tick();
        bus.resultado = 16'd42;
        bus.done      = 1'b1;
        rises      = 0;
        prev_valid = bus.bcd_valid;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.bcd_valid && !prev_valid) rises++;
            prev_valid = bus.bcd_valid;
        end
        chk("t5_rises", 32'(rises), 32'd1);
        chk("t5_bcd",   32'(bus.bcd), 32'h00042);

        // 6. reset in the middle of SHIFT aborts the conversion
        bus.done = 1'b0;
        tick();
        bus.resultado = 16'd1234;
        bus.done      = 1'b1;
        tick();                         // capture edge
        bus.done = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        rst = 1'b1;
        tick();                         // SHIFT edge 8
        chk("t6_bcd",   32'(bus.bcd), 32'd0);
        chk("t6_neg",   32'(bus.negativo), 32'd0);
        chk("t6_valid", 32'(bus.bcd_valid), 32'd0);
        chk("t6_busy",  32'(bus.busy), 32'd0);
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.bcd_valid) rises++;
        end
        chk("t6_no_valid", 32'(rises), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
